fp_mul_result_stage: RTL and testbench

FP_MUL_RESULT_STAGE -- requirements
Module: fp_mul_result_stage

---
 rtl/fp_mul_result_stage.sv | 194 +++++++++++++++++++
 tb/tb_fp_mul_result_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_result_stage.sv
// Two-stage result stage for an IEEE-754 single-precision Vedic multiplier.
// S1 classifies the operands and computes the exponent. S2 packs the result and raises its flags.
// Optional sticky flag accumulation is controlled by the macro FPMUL_STICKY_FLAGS_EN.
module fp_mul_result_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [23:0] in_man,
    input  logic        in_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_exception,
    input  logic        flag_clr,
    output logic [2:0]  flag_sticky
);

    localparam int unsigned W  = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned FW = 23;
    localparam int unsigned XW = 10;
    localparam int unsigned FLW = 3;

    localparam logic [EW-1:0]        EXP_ALL1 = 8'hFF;
    localparam logic [XW-1:0]        BIAS     = 10'd127;
    localparam logic signed [XW-1:0] EXP_OVF  = 10'sd255;
    localparam logic signed [XW-1:0] EXP_UNF  = 10'sd0;
    localparam logic [W-1:0]         QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Handshake: each stage can accept when it is empty or when it is being drained.
    logic s1_valid;
    logic s2_valid;
    logic s1_adv_c;
    logic s2_adv_c;

    assign s2_adv_c  = !s2_valid || out_ready;
    assign s1_adv_c  = !s1_valid || s2_adv_c;
    assign in_ready  = s1_adv_c;
    assign out_valid = s2_valid;

    // Operand classification. A zero exponent means zero because denormals are flushed.
    logic [EW-1:0] a_exp_c;
    logic [EW-1:0] b_exp_c;
    logic          a_zero_c;
    logic          b_zero_c;
    logic          a_inf_c;
    logic          b_inf_c;
    logic          a_nan_c;
    logic          b_nan_c;

    assign a_exp_c  = in_a[30:23];
    assign b_exp_c  = in_b[30:23];
    assign a_zero_c = (a_exp_c == '0);
    assign b_zero_c = (b_exp_c == '0);
    assign a_inf_c  = (a_exp_c == EXP_ALL1) && (in_a[FW-1:0] == '0);
    assign b_inf_c  = (b_exp_c == EXP_ALL1) && (in_b[FW-1:0] == '0);
    assign a_nan_c  = (a_exp_c == EXP_ALL1) && (in_a[FW-1:0] != '0);
    assign b_nan_c  = (b_exp_c == EXP_ALL1) && (in_b[FW-1:0] != '0);

    cls_e                  s1_cls_c;
    logic signed [XW-1:0]  s1_exp_c;

    always_comb begin
        s1_cls_c = CLS_NORM;
        if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (b_inf_c && a_zero_c)) begin
            s1_cls_c = CLS_NAN;
        end else if (a_inf_c || b_inf_c) begin
            s1_cls_c = CLS_INF;
        end else if (a_zero_c || b_zero_c) begin
            s1_cls_c = CLS_ZERO;
        end
    end

    // Biased exponent sum. Ten bits hold the full range from -125 to 382 without wrapping.
    assign s1_exp_c = $signed(XW'(a_exp_c) + XW'(b_exp_c) + XW'(in_carry) - BIAS);

    // S1 register: class, sign, exponent and the fraction taken from the mantissa product.
    cls_e                 s1_cls;
    logic                 s1_sign;
    logic signed [XW-1:0] s1_exp;
    logic [FW-1:0]        s1_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cls   <= CLS_NORM;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cls  <= s1_cls_c;
                s1_sign <= in_a[31] ^ in_b[31];
                s1_exp  <= s1_exp_c;
                s1_frac <= in_man[23:1];
            end
        end
    end

    // Pack the result. Because this is one priority chain, at most one flag is set.
    logic [W-1:0] pack_res_c;
    logic         pack_ovf_c;
    logic         pack_unf_c;
    logic         pack_exc_c;

    always_comb begin
        pack_res_c = '0;
        pack_ovf_c = 1'b0;
        pack_unf_c = 1'b0;
        pack_exc_c = 1'b0;
        case (s1_cls)
            CLS_NAN: begin
                pack_res_c = QNAN;
                pack_exc_c = 1'b1;
            end
            CLS_INF: begin
                pack_res_c = {s1_sign, EXP_ALL1, FW'(0)};
            end
            CLS_ZERO: begin
                pack_res_c = {s1_sign, (W-1)'(0)};
            end
            default: begin
                if (s1_exp >= EXP_OVF) begin
                    pack_res_c = {s1_sign, EXP_ALL1, FW'(0)};
                    pack_ovf_c = 1'b1;
                end else if (s1_exp <= EXP_UNF) begin
                    pack_res_c = {s1_sign, (W-1)'(0)};
                    pack_unf_c = 1'b1;
                end else begin
                    pack_res_c = {s1_sign, s1_exp[EW-1:0], s1_frac};
                end
            end
        endcase
    end

    // S2 register drives the outputs directly and holds them while out_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid      <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_exception <= 1'b0;
        end else if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= pack_res_c;
                out_overflow  <= pack_ovf_c;
                out_underflow <= pack_unf_c;
                out_exception <= pack_exc_c;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = in_man[0];

`ifdef FPMUL_STICKY_FLAGS_EN
    // On a clear, only the flags of a transfer in the same cycle are kept.
    logic           out_xfer_c;
    logic [FLW-1:0] xfer_flags_c;

    assign out_xfer_c   = s2_valid && out_ready;
    assign xfer_flags_c = {out_exception, out_underflow, out_overflow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_sticky <= '0;
        end else if (flag_clr) begin
            flag_sticky <= out_xfer_c ? xfer_flags_c : FLW'(0);
        end else if (out_xfer_c) begin
            flag_sticky <= flag_sticky | xfer_flags_c;
        end
    end
`else
    logic unused_clr;
    assign unused_clr  = flag_clr;
    assign flag_sticky = FLW'(0);
`endif

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Self-checking bench for fp_mul_result_stage. An arithmetic reference model feeds a
// scoreboard, and the DUT outputs are compared against it on every cycle.
module tb_fp_mul_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [23:0] in_man;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_exception;
    logic        flag_clr;
    logic [2:0]  flag_sticky;

    fp_mul_result_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_man       (in_man),
        .in_carry     (in_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_exception(out_exception),
        .flag_clr     (flag_clr),
        .flag_sticky  (flag_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        ex;
    } exp_t;

    typedef struct {
        int   acc;
        exp_t e;
    } entry_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_out = -100;
    entry_t q[$];
    logic [2:0] sticky_m = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the product class and exponent are computed with plain integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [23:0] man, input logic c);
        exp_t r;
        int   ea, eb, e;
        bit   an, bn, ai, bi, az, bz, s;
        r  = '0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        s  = a[31] ^ b[31];
        if (an || bn || ((ai || bi) && (az || bz))) begin
            r.res = 32'h7FC00000;
            r.ex  = 1'b1;
        end else if (ai || bi) begin
            r.res = s ? 32'hFF800000 : 32'h7F800000;
        end else if (az || bz) begin
            r.res = s ? 32'h80000000 : 32'h00000000;
        end else begin
            e = ea + eb - 127 + (c ? 1 : 0);
            if (e >= 255) begin
                r.res = s ? 32'hFF800000 : 32'h7F800000;
                r.ov  = 1'b1;
            end else if (e <= 0) begin
                r.res = s ? 32'h80000000 : 32'h00000000;
                r.un  = 1'b1;
            end else begin
                r.res = {s, 8'(e), man[23:1]};
            end
        end
        return r;
    endfunction

    // Directed vectors {a, b, man, carry} with hand-computed {result, ov, un, ex}.
    localparam int NV = 13;
    logic [31:0] va   [NV] = '{32'h3FC00000, 32'h7F000000, 32'h7F800000, 32'hFF800000,
                               32'h80800000, 32'h7F800001, 32'h80000000, 32'h7F000000,
                               32'h7F000000, 32'h00800000, 32'h00800000, 32'h3F800000,
                               32'h00000000};
    logic [31:0] vb   [NV] = '{32'h40000000, 32'h7F000000, 32'h00000000, 32'h3F800000,
                               32'h00800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                               32'h3F800000, 32'h3F000000, 32'h3F000000, 32'hFF800000,
                               32'hFF800000};
    logic [23:0] vm   [NV] = '{24'h800000, 24'h000000, 24'h000000, 24'h000000,
                               24'h000000, 24'h800000, 24'h800000, 24'hC00001,
                               24'h800000, 24'h800000, 24'h800000, 24'h800000,
                               24'h000000};
    logic        vc   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t        vexp [NV] = '{{32'h40400000, 1'b0, 1'b0, 1'b0},
                               {32'h7F800000, 1'b1, 1'b0, 1'b0},
                               {32'h7FC00000, 1'b0, 1'b0, 1'b1},
                               {32'hFF800000, 1'b0, 1'b0, 1'b0},
                               {32'h80000000, 1'b0, 1'b1, 1'b0},
                               {32'h7FC00000, 1'b0, 1'b0, 1'b1},
                               {32'h80000000, 1'b0, 1'b0, 1'b0},
                               {32'h7F600000, 1'b0, 1'b0, 1'b0},
                               {32'h7F800000, 1'b1, 1'b0, 1'b0},
                               {32'h00000000, 1'b0, 1'b1, 1'b0},
                               {32'h00C00000, 1'b0, 1'b0, 1'b0},
                               {32'hFF800000, 1'b0, 1'b0, 1'b0},
                               {32'h7FC00000, 1'b0, 1'b0, 1'b1}};

    // Scoreboard process. Outputs are sampled on the falling edge.
    int   avail;
    bit   ev;
    bit   xfer;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_result", out_result, 32'd0);
            chk("rst_flags", 32'({out_exception, out_underflow, out_overflow}), 32'd0);
            chk("rst_sticky", 32'(flag_sticky), 32'd0);
            q.delete();
            last_out = -100;
            sticky_m = 3'b000;
        end else begin
            ev   = 1'b0;
            xfer = 1'b0;
            cur  = '0;
            if (q.size() > 0) begin
                avail = q[0].acc + 2;
                if (last_out + 1 > avail) avail = last_out + 1;
                ev = (cyc >= avail);
            end
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            if (ev && out_valid) begin
                chk("out_result", out_result, q[0].e.res);
                chk("out_flags", 32'({out_exception, out_underflow, out_overflow}),
                    32'({q[0].e.ex, q[0].e.un, q[0].e.ov}));
            end
            chk("flag_sticky", 32'(flag_sticky), 32'(sticky_m));
            if (ev && out_ready) begin
                cur      = q[0].e;
                xfer     = 1'b1;
                last_out = cyc;
                void'(q.pop_front());
            end
`ifdef FPMUL_STICKY_FLAGS_EN
            if (flag_clr) sticky_m = xfer ? {cur.ex, cur.un, cur.ov} : 3'b000;
            else if (xfer) sticky_m = sticky_m | {cur.ex, cur.un, cur.ov};
`endif
            if (in_valid && in_ready) q.push_back('{acc: cyc, e: model(in_a, in_b, in_man, in_carry)});
        end
    end

    task automatic send(input int i);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = va[i];
        in_b     = vb[i];
        in_man   = vm[i];
        in_carry = vc[i];
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (q.size() != 0 || out_valid); k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic clr_pulse();
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_man    = '0;
        in_carry  = 1'b0;
        out_ready = 1'b1;
        flag_clr  = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cur = model(va[i], vb[i], vm[i], vc[i]);
            chk($sformatf("model_res_%0d", i), cur.res, vexp[i].res);
            chk($sformatf("model_flags_%0d", i), 32'({cur.ex, cur.un, cur.ov}),
                32'({vexp[i].ex, vexp[i].un, vexp[i].ov}));
        end

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-cycle latency for 1.5 * 2.0.
        send(0);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("lat_cycle2_result", out_result, 32'h40400000);
        chk("lat_cycle2_flags", 32'({out_exception, out_underflow, out_overflow}), 32'd0);
        drain();

        for (int i = 0; i < NV; i++) send(i);
        drain();

        // Backpressure: out_ready is low for 3 cycles starting with the first out_valid.
        send(0);
        send(1);
        out_ready = 1'b0;
        fork
            begin
                send(2);
                send(3);
            end
            begin
                @(negedge clk);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_held_result", out_result, 32'h40400000);
                @(posedge clk);
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Sticky flags, plus a clear that coincides with the NaN transfer.
        clr_pulse();
        send(1);
        send(4);
        drain();
`ifdef FPMUL_STICKY_FLAGS_EN
        chk("sticky_ovf_unf", 32'(flag_sticky), 32'd3);
`else
        chk("sticky_tied", 32'(flag_sticky), 32'd0);
`endif
        clr_pulse();
        chk("sticky_cleared", 32'(flag_sticky), 32'd0);
        send(1);
        send(2);
        @(posedge clk);
        #1;
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
`ifdef FPMUL_STICKY_FLAGS_EN
        chk("sticky_clr_coincident", 32'(flag_sticky), 32'd4);
`else
        chk("sticky_clr_ignored", 32'(flag_sticky), 32'd0);
`endif
        drain();

        // A mid-flight reset discards both entries that are in the pipeline.
        send(7);
        send(8);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_empty", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(10);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
